// File: rtl/sdlc_rx_deframer.sv
// SDLC/HDLC receive deframer: flag hunt, zero destuffing, 16-bit word assembly, CRC check, 4-word FIFO.
// Optional macro SDLC_RX_ABORT_EN: seven consecutive ones inside a frame abort it.
module sdlc_rx_deframer #(
    parameter logic [15:0] CRC_POLY  = 16'h1021,
    parameter logic [15:0] CRC_INIT  = 16'hFFFF,
    parameter logic [15:0] CRC_MATCH = 16'h1D0F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_clk,
    input  logic        rx_data,
    output logic [15:0] rx_word,
    output logic        rx_drq,
    input  logic        rx_rd,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        in_frame
);

    typedef enum logic [1:0] {HUNT, SYNC, DATA} state_t;

    state_t       state, state_nxt;
    logic         ok_nxt, err_nxt;
    logic [1:0]   clk_sync, data_sync;
    logic         clk_prev;
    logic [6:0]   flag_sr;
    logic [2:0]   ones;
    logic [6:0]   dline;
    logic [2:0]   dl_cnt;
    logic [14:0]  word_sr;
    logic [3:0]   bit_cnt;
    logic [2:0]   word_cnt;
    logic [15:0]  crc;
    logic         ovf;
    logic [15:0]  mem [4];
    logic [1:0]   wr_ptr, rd_ptr;
    logic [2:0]   count;

    logic         bit_vld, bit_in, is_flag, stuffed, run7, dl_push, emit, word_done;
    logic         to_hunt, frame_good, pop, push_ok;
    logic [7:0]   flag_nxt;
    logic [15:0]  word_new;

    function automatic logic [15:0] crc_word(input logic [15:0] c_in, input logic [15:0] w);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ w[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '0;
            data_sync <= '0;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], rx_clk};
            data_sync <= {data_sync[0], rx_data};
            clk_prev  <= clk_sync[1];
        end
    end

    // One line bit per synchronised rising edge of rx_clk.
    assign bit_vld  = clk_sync[1] & ~clk_prev;
    assign bit_in   = data_sync[1];
    assign flag_nxt = {flag_sr, bit_in};
    assign is_flag  = bit_vld && (flag_nxt == 8'h7E);
    assign stuffed  = bit_vld && !bit_in && (ones == 3'd5);
    assign run7     = bit_vld && bit_in && (ones >= 3'd6);
    // Bits are held back 7 places so a flag can be erased before it reaches the word stream.
    assign dl_push   = bit_vld && (state != HUNT) && !stuffed && !is_flag;
    assign emit      = dl_push && (dl_cnt == 3'd7);
    assign word_new  = {word_sr, dline[6]};
    assign word_done = emit && (bit_cnt == 4'd15);
    assign to_hunt   = (state != HUNT) && (state_nxt == HUNT);
    assign frame_good = (crc == CRC_MATCH) && (bit_cnt == 4'd0) && (word_cnt >= 3'd2) && !ovf;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            HUNT: if (is_flag) state_nxt = SYNC;
            SYNC: begin
                if (is_flag)   state_nxt = SYNC;
                else if (run7) state_nxt = HUNT;
                else if (emit) state_nxt = DATA;
            end
            DATA: begin
                if (is_flag) begin
                    state_nxt = SYNC;
                    ok_nxt    = frame_good;
                    err_nxt   = !frame_good;
                end
`ifdef SDLC_RX_ABORT_EN
                else if (run7) begin
                    state_nxt = HUNT;
                    err_nxt   = 1'b1;
                end
`endif
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_sr  <= '0;
            ones     <= '0;
            dline    <= '0;
            dl_cnt   <= '0;
            word_sr  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            crc      <= CRC_INIT;
        end else if (bit_vld) begin
            flag_sr <= flag_nxt[6:0];
            ones    <= bit_in ? ((ones == 3'd7) ? ones : ones + 3'd1) : 3'd0;
            if (is_flag || to_hunt) begin
                dl_cnt <= '0;
            end else if (dl_push) begin
                dline <= {dline[5:0], bit_in};
                if (dl_cnt != 3'd7) dl_cnt <= dl_cnt + 3'd1;
            end
            if (is_flag) begin
                crc      <= CRC_INIT;
                bit_cnt  <= '0;
                word_cnt <= '0;
            end else if (emit) begin
                word_sr <= word_new[14:0];
                bit_cnt <= bit_cnt + 4'd1;
                if (word_done) begin
                    crc <= crc_word(crc, word_new);
                    if (word_cnt != 3'd7) word_cnt <= word_cnt + 3'd1;
                end
            end
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign pop     = rx_rd && (count != 3'd0);
    assign push_ok = word_done && ((count != 3'd4) || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            case ({push_ok, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (is_flag)                   ovf <= 1'b0;
            else if (word_done && !push_ok) ovf <= 1'b1;
        end
    end

    // NOTE: storage is not reset; the empty flag gates rx_word so stale entries never show.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= word_new;
    end

    assign rx_drq   = (count != 3'd0);
    assign rx_word  = rx_drq ? mem[rd_ptr] : 16'h0000;
    assign in_frame = (state != HUNT);

endmodule

// File: tb/tb_sdlc_rx_deframer.sv
// Self-checking bench for sdlc_rx_deframer: frames are built as bit queues, modelled, stuffed and sent.
// Abort scenario runs only when SDLC_RX_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_sdlc_rx_deframer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_clk;
    logic        rx_data;
    logic        rx_rd;
    logic [15:0] rx_word;
    logic        rx_drq, frame_ok, frame_err, in_frame;

    always #5 clk = ~clk;

    sdlc_rx_deframer dut (
        .clk       (clk),
        .reset     (reset),
        .rx_clk    (rx_clk),
        .rx_data   (rx_data),
        .rx_word   (rx_word),
        .rx_drq    (rx_drq),
        .rx_rd     (rx_rd),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .in_frame  (in_frame)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic [1:0]  st_q[$];    // {ok, err}
    bit          rd_en = 1'b1;
    bit          pl[$];      // destuffed payload bits of the frame under construction
    logic [71:0] check_str = "123456789";

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] crc_of(input int n);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        for (int i = 0; i < n; i++) begin
            fb = c[15] ^ pl[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    function automatic logic [15:0] word_at(input int k);
        logic [15:0] w = '0;
        for (int i = 0; i < 16; i++) w = {w[14:0], pl[16*k+i]};
        return w;
    endfunction

    function automatic int stuff_len(input logic [15:0] w);
        int n = 0;
        int run = 0;
        for (int i = 15; i >= 0; i--) begin
            n++;
            run = w[i] ? run + 1 : 0;
            if (run == 5) begin n++; run = 0; end
        end
        return n;
    endfunction

    task automatic push_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) pl.push_back(w[i]);
    endtask

    task automatic add_fcs();
        push_word(~crc_of(pl.size()));
    endtask

    // ---------------- line driver ----------------
    task automatic line_bit(input bit b);
        @(negedge clk); rx_data = b;
        repeat (3) @(negedge clk); rx_clk = 1'b1;
        repeat (4) @(negedge clk); rx_clk = 1'b0;
    endtask

    task automatic send_flag();
        logic [7:0] f = 8'h7E;
        for (int i = 7; i >= 0; i--) line_bit(f[i]);
    endtask

    task automatic send_ones(input int n);
        for (int i = 0; i < n; i++) line_bit(1'b1);
    endtask

    task automatic send_stuffed();
        int run = 0;
        for (int i = 0; i < pl.size(); i++) begin
            line_bit(pl[i]);
            run = pl[i] ? run + 1 : 0;
            if (run == 5) begin line_bit(1'b0); run = 0; end
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
        check("fifo_drain_left", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("rx_drq_after_drain", rx_drq, 1'b0);
    endtask

    // Predict words and verdict from the frame rules, then send the frame.
    task automatic model_and_send(input bit shared);
        int          nbits, nw, nkeep;
        bit          ovf, good;
        logic [15:0] c;
        nbits = pl.size();
        nw    = nbits / 16;
        c     = crc_of(nw * 16);
        ovf   = !rd_en && (nw > 4);
        good  = (nbits % 16 == 0) && (nw >= 2) && (c == 16'h1D0F) && !ovf;
        nkeep = ovf ? 4 : nw;
        for (int k = 0; k < nkeep; k++) exp_q.push_back(word_at(k));
        st_q.push_back(good ? 2'b10 : 2'b01);
        send_flag();
        if (shared) begin
            send_ones(6);
            line_bit(1'b0);
        end else begin
            send_flag();
        end
        send_stuffed();
        check("in_frame_before_close", in_frame, 1'b1);
        send_flag();
        send_ones(9);
        check("status_pulses_pending", st_q.size(), 0);
        st_q.delete();
        check("in_frame_after_idle", in_frame, 1'b0);
        if (rd_en) wait_drain();
    endtask

    task automatic directed_good();
        pl.delete();
        push_word(16'h0015); push_word(16'h0000); push_word(16'h0000); push_word(16'hFF00);
        add_fcs();
        model_and_send(1'b0);
    endtask

    // ---------------- compare process ----------------
    initial begin
        rx_rd = 1'b0;
        forever begin
            @(negedge clk);
            rx_rd = 1'b0;
            if (reset !== 1'b1) begin
                if (rx_drq) begin
                    if (exp_q.size() == 0) begin
                        fail_now("spurious_word", rx_word);
                        if (rd_en) rx_rd = 1'b1;
                    end else begin
                        check("rx_word", rx_word, exp_q[0]);
                        if (rd_en) begin
                            rx_rd = 1'b1;
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (frame_ok || frame_err) begin
                    if (st_q.size() == 0) fail_now("spurious_status", {frame_ok, frame_err});
                    else begin
                        check("status_ok_err", {frame_ok, frame_err}, st_q[0]);
                        void'(st_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          kind, nd, idx;
        bit          shared;
        logic [15:0] w;

        reset   = 1'b1;
        rx_clk  = 1'b0;
        rx_data = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_rx_drq", rx_drq, 1'b0);
        check("reset_rx_word", rx_word, 16'h0000);
        check("reset_frame_ok", frame_ok, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_in_frame", in_frame, 1'b0);
        reset = 1'b0;
        send_ones(10);

        // Model pins: CRC-16/CCITT-FALSE check value, stuffed lengths, good-frame residue.
        pl.delete();
        for (int i = 71; i >= 0; i--) pl.push_back(check_str[i]);
        check("pin_crc_123456789", crc_of(72), 16'h29B1);
        check("pin_stuff_len_ffff", stuff_len(16'hFFFF), 19);
        check("pin_stuff_len_7e7e", stuff_len(16'h7E7E), 18);

        // Good reference frame.
        pl.delete();
        push_word(16'h0015); push_word(16'h0000); push_word(16'h0000); push_word(16'hFF00);
        add_fcs();
        check("pin_good_residue", crc_of(80), 16'h1D0F);
        model_and_send(1'b0);

        // Same frame with one payload bit flipped on the line.
        pl.delete();
        push_word(16'h0015); push_word(16'h0000); push_word(16'h0000); push_word(16'hFF00);
        add_fcs();
        pl[15] = ~pl[15];
        check("pin_flip_word0", word_at(0), 16'h0014);
        check("pin_flip_residue_bad", crc_of(80) == 16'h1D0F, 1'b0);
        model_and_send(1'b0);

        // All-ones payload, heavily stuffed.
        pl.delete();
        push_word(16'hFFFF); push_word(16'hFFFF);
        add_fcs();
        model_and_send(1'b1);

        // Six-word frame with reads held off: overflow, then a clean frame.
        rd_en = 1'b0;
        pl.delete();
        push_word(16'h1111); push_word(16'h2222); push_word(16'h3333);
        push_word(16'h4444); push_word(16'h5555);
        add_fcs();
        model_and_send(1'b0);
        check("overflow_fifo_full", rx_drq, 1'b1);
        rd_en = 1'b1;
        wait_drain();
        directed_good();

`ifdef SDLC_RX_ABORT_EN
        // Eight raw ones after three words abort the frame; the three words stay readable.
        pl.delete();
        push_word(16'h0015); push_word(16'h5A5A); push_word(16'h1234);
        for (int k = 0; k < 3; k++) exp_q.push_back(word_at(k));
        st_q.push_back(2'b01);
        send_flag(); send_flag();
        send_stuffed();
        send_ones(8);
        repeat (4) @(negedge clk);
        check("abort_status_pending", st_q.size(), 0);
        st_q.delete();
        check("abort_in_frame", in_frame, 1'b0);
        wait_drain();
        directed_good();
`endif

        // Reset in the middle of a frame: first word is already out, the rest is discarded.
        pl.delete();
        push_word(16'h0015); push_word(16'h0000);
        exp_q.push_back(16'h0015);
        send_flag(); send_flag();
        send_stuffed();
        repeat (20) @(negedge clk);
        check("midreset_word_read", exp_q.size(), 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_rx_drq", rx_drq, 1'b0);
        check("midreset_rx_word", rx_word, 16'h0000);
        check("midreset_frame_ok", frame_ok, 1'b0);
        check("midreset_frame_err", frame_err, 1'b0);
        check("midreset_in_frame", in_frame, 1'b0);
        exp_q.delete();
        st_q.delete();
        reset = 1'b0;
        send_ones(10);
        check("postreset_no_pulse", st_q.size(), 0);
        directed_good();

        // Randomised frames: good, bit error, ragged length, single word.
        for (int f = 0; f < 12; f++) begin
            kind   = $urandom_range(0, 3);
            shared = 1'($urandom_range(0, 1));
            nd     = $urandom_range(1, 4);
            pl.delete();
            if (kind == 3) begin
                push_word(16'($urandom));
            end else begin
                for (int k = 0; k < nd; k++) begin
                    case ($urandom_range(0, 5))
                        0:       w = 16'hFFFF;
                        1:       w = 16'h7E7E;
                        2:       w = 16'hFC3F;
                        default: w = 16'($urandom);
                    endcase
                    push_word(w);
                end
                add_fcs();
                if (kind == 1) begin
                    idx = $urandom_range(0, pl.size() - 1);
                    pl[idx] = ~pl[idx];
                end else if (kind == 2) begin
                    nd = $urandom_range(1, 15);
                    for (int k = 0; k < nd; k++) pl.push_back(1'($urandom));
                end
            end
            model_and_send(shared);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sdlc_rx_deframer.md
SDLC_RX_DEFRAMER -- requirements
Module: sdlc_rx_deframer

Interface
REQ-001 Parameter CRC_POLY, default 16'h1021, CRC generator polynomial (x^16 term implied).
REQ-002 Parameter CRC_INIT, default 16'hFFFF, CRC register value loaded at each opening flag.
REQ-003 Parameter CRC_MATCH, default 16'h1D0F, CRC register value after a good frame including its FCS.
REQ-004 clk  in  1  system clock; the only clock in the block.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rx_clk  in  1  line bit clock, asynchronous to clk.
REQ-007 rx_data  in  1  line serial data.
REQ-008 rx_word  out  16  head word of the receive FIFO.
REQ-009 rx_drq  out  1  high while the receive FIFO is non-empty.
REQ-010 rx_rd  in  1  one-clk pop strobe; ignored when the FIFO is empty.
REQ-011 frame_ok  out  1  one-clk pulse: closing flag seen with valid CRC and length.
REQ-012 frame_err  out  1  one-clk pulse: frame ended by CRC, length, overflow or abort error.
REQ-013 in_frame  out  1  high from the opening flag until the frame ends.

Function
REQ-014 rx_clk and rx_data SHALL be double-synchronised into clk; one line bit is sampled per synchronised rx_clk rising edge.
REQ-015 States SHALL be HUNT, SYNC and DATA; reset state HUNT.
REQ-016 HUNT->SYNC on pattern 0111_1110; SYNC stays SYNC on back-to-back flags (shared zero allowed); SYNC->DATA on the first non-flag data bit.
REQ-017 A zero after five consecutive ones SHALL be discarded (destuffed) and SHALL NOT count toward the ones run.
REQ-018 Flag bits SHALL never enter the word stream; a 7-bit delay line is cleared on flag detection.
REQ-019 Destuffed bits SHALL be assembled MSB-first; every 16th bit pushes one word into the FIFO and updates the CRC.
REQ-020 CRC: per bit, MSB-first, fb = crc[15] ^ bit, crc = {crc[14:0],1'b0} ^ (fb ? CRC_POLY : 0).
REQ-021 Closing flag in DATA: frame_ok if crc == CRC_MATCH, bit count is a multiple of 16, word count >= 2, and no overflow; otherwise frame_err. Then go to SYNC.
REQ-022 FCS words SHALL be pushed like data; software discards the final word.
REQ-023 FIFO depth SHALL be 4 words; rx_word is valid while rx_drq is high.
REQ-024 Push to a full FIFO SHALL drop the word and set a sticky overflow flag, cleared at the next opening flag.
REQ-025 Simultaneous push and rx_rd on a full FIFO SHALL succeed with no overflow.
REQ-026 Status pulses SHALL be asserted 1 clk after the synchronised edge that completes the closing flag.
REQ-027 Seven or more consecutive ones in HUNT or SYNC SHALL return to HUNT without a status pulse.

Reset
REQ-028 Reset SHALL force: state HUNT, FIFO empty, rx_drq=0, rx_word=16'h0000, frame_ok=0, frame_err=0, in_frame=0, CRC=CRC_INIT, overflow=0, synchronisers=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no status pulse after release.

Configuration
REQ-030 With SDLC_RX_ABORT_EN defined, seven consecutive ones in DATA SHALL abort the frame: pulse frame_err, go to HUNT, keep FIFO contents.
REQ-031 Without SDLC_RX_ABORT_EN, ones runs in DATA SHALL NOT be checked; a closing flag ends the frame and the CRC check rejects bad frames.

Verification
REQ-032 Flags 7E 7E, words 0015 0000 0000 FF00, then a valid complemented FCS and 7E -> 5 words are read in order, frame_ok=1 pulse, frame_err=0.
REQ-033 Same frame with one payload bit flipped -> 5 words are read, frame_err pulse, no frame_ok.
REQ-034 Payload 16'hFFFF (stuffed on the line) -> rx_word=16'hFFFF, with no extra bits and correct word alignment.
REQ-035 Six-word frame with rx_rd held low -> the first 4 words are kept, the rest are dropped, frame_err at the closing flag, the next good frame gives frame_ok.
REQ-036 SDLC_RX_ABORT_EN defined, 8 ones after 3 data words -> frame_err pulse, state HUNT, in_frame=0.
REQ-037 Reset pulse after 2 words -> all outputs at reset values, and a following good frame is received cleanly.
